mine_placer: RTL

//  Populates the minesweeper board memory before play, sitting directly upstream of the board's write port.

---
 rtl/minesweeper_pkg.sv | 33 +++
 rtl/mine_lfsr.sv | 26 ++
 rtl/mine_placer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: placer state encoding, mine marker value
// and the cell index helper used by both the placer and the board.
package minesweeper_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PLACE = 3'd2,
    INC   = 3'd3,
    MARK  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Galois feedback taps for the 16-bit mine LFSR.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Marker for the default 4-bit cell; wider cells use mine_value().
  localparam logic [3:0] MINE_VALUE = 4'hF;

  // All-ones marker for a cell of bus_width bits. Neighbour counts never
  // exceed 8, so with at least 4 bits this value cannot alias a count.
  function automatic logic [31:0] mine_value(input int unsigned bus_width);
    return (32'd1 << bus_width) - 32'd1;
  endfunction

  // Row-major cell index, x fastest.
  function automatic int unsigned cell_idx(input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned width);
    return y * width + x;
  endfunction

endpackage

// File: rtl/mine_lfsr.sv
// Free-running 16-bit Galois LFSR that supplies mine candidates.
module mine_lfsr
  import minesweeper_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  // An all-zero register would lock up, so a zero seed becomes 1.
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // Shift right every cycle; fold the taps back in when a 1 falls out.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED_NZ;
    end else if (q[0]) begin
      q <= (q >> 1) ^ LFSR_MASK;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Populates the board before play: clear every cell, pick NUM_MINES distinct
// mine cells (never the first-click cell), pulse incAdjacent once per mine,
// then stamp each mine cell with the all-ones marker.
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          HEIGHT    = 8,
  parameter int          BUS_WIDTH = 4,
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         XW        = $clog2(WIDTH),
  localparam int         YW        = $clog2(HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [XW-1:0]        safeX,
  input  logic [YW-1:0]        safeY,
  output logic                 busy,
  output logic                 done,
  output logic                 writeEn,
  output logic                 incAdjacent,
  output logic [XW-1:0]        writeX,
  output logic [YW-1:0]        writeY,
  output logic [BUS_WIDTH-1:0] writeValue,
  output logic [2:0]           debug_state
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int IW    = $clog2(CELLS);
  localparam int CW    = $clog2(CELLS + 1);
  localparam logic [BUS_WIDTH-1:0] MINE_VAL = BUS_WIDTH'(mine_value(BUS_WIDTH));
  localparam logic [IW-1:0]        LAST_IDX = IW'(CELLS - 1);
  localparam logic [CW-1:0]        MINES_CW = CW'(NUM_MINES);

  if (NUM_MINES < 1 || NUM_MINES > CELLS - 1) begin : g_bad_num_mines
    $error("mine_placer: NUM_MINES must be in 1..WIDTH*HEIGHT-1");
  end
  if (BUS_WIDTH < 4) begin : g_bad_bus_width
    $error("mine_placer: BUS_WIDTH must be at least 4");
  end

  // Handshake: start is a one-cycle request taken only while busy is low
  // (IDLE); busy rises the next cycle and stays high through the done pulse,
  // and any start seen while busy is dropped rather than queued.

  state_t              state;
  state_t              state_n;
  logic [IW-1:0]       idx;
  logic [CELLS-1:0]    bitmap;
  logic [CW-1:0]       count;
  logic [XW-1:0]       safe_x_r;
  logic [YW-1:0]       safe_y_r;
  logic [15:0]         lfsr_q;
  logic [XW-1:0]       cand_x;
  logic [YW-1:0]       cand_y;
  logic [IW-1:0]       cand_idx;
  logic                cand_in_range;
  logic                cand_ok;
  logic                idx_last;
  logic                walking;
  logic                unused_lfsr_bits;

  mine_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign cand_x           = lfsr_q[XW-1:0];
  assign cand_y           = lfsr_q[XW+YW-1:XW];
  assign unused_lfsr_bits = ^lfsr_q[15:XW+YW];
  assign cand_in_range    = (int'(cand_x) < WIDTH) && (int'(cand_y) < HEIGHT);
  assign cand_idx         = IW'(cell_idx(32'(cand_x), 32'(cand_y), WIDTH));
  assign idx_last         = (idx == LAST_IDX);
  assign walking          = (state == CLEAR) || (state == INC) || (state == MARK);

  // Candidate is usable when on the board, not already a mine, not the safe cell.
  always_comb begin
    cand_ok = 1'b0;
    if (cand_in_range) begin
      cand_ok = !bitmap[cand_idx] && !((cand_x == safe_x_r) && (cand_y == safe_y_r));
    end
  end

  // Next-state decode for the fill sequence.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)              state_n = CLEAR;
      CLEAR:   if (idx_last)           state_n = PLACE;
      PLACE:   if (count == MINES_CW)  state_n = INC;
      INC:     if (idx_last)           state_n = MARK;
      MARK:    if (idx_last)           state_n = DONE;
      DONE:                            state_n = IDLE;
      default:                         state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath: safe-cell latch, bitmap, mine count and the scan counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      bitmap   <= '0;
      count    <= '0;
      safe_x_r <= '0;
      safe_y_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            safe_x_r <= safeX;
            safe_y_r <= safeY;
            count    <= '0;
          end
        end
        CLEAR: bitmap[idx] <= 1'b0;
        PLACE: begin
          // The count is registered, so the cycle that sees it full places nothing.
          if ((count != MINES_CW) && cand_ok) begin
            bitmap[cand_idx] <= 1'b1;
            count            <= count + CW'(1);
          end
        end
        default: ;
      endcase
      // The scan restarts at 0 whenever a state is left.
      if (state_n != state) begin
        idx <= '0;
      end else if (walking) begin
        idx <= idx + IW'(1);
      end
    end
  end

  // Board-side outputs, decoded only from registered state.
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    writeEn     = (state == CLEAR) || ((state == MARK) && bitmap[idx]);
    incAdjacent = (state == INC) && bitmap[idx];
    writeValue  = ((state == MARK) && bitmap[idx]) ? MINE_VAL : '0;
    writeX      = XW'(int'(idx) % WIDTH);
    writeY      = YW'(int'(idx) / WIDTH);
    debug_state = state;
  end

endmodule
